// File: rtl/registro_ataques_pkg.sv
// Shared definitions for the battleship attack register: board geometry,
// game FSM states, RGB status codes and a ship-cell counting helper.
package registro_ataques_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int NUM_CELULAS = NUM_COLUNAS * NUM_LINHAS;

  typedef enum logic [1:0] {
    POSICIONAR = 2'd0,
    ATACAR     = 2'd1,
    VITORIA    = 2'd2,
    DERROTA    = 2'd3
  } estado_t;

  localparam logic [1:0] LED_APAGADO = 2'b00;
  localparam logic [1:0] LED_ERRO    = 2'b01;
  localparam logic [1:0] LED_ACERTO  = 2'b10;
  localparam logic [1:0] LED_VITORIA = 2'b11;

  // Cell (c, r) lives at bit c*NUM_LINHAS + r.
  typedef logic [NUM_CELULAS-1:0] mapa_t;

  // Number of ship cells in a map (at most 35, fits in 6 bits).
  function automatic logic [5:0] contar_celulas(input mapa_t mapa);
    logic [5:0] total;
    total = '0;
    for (int i = 0; i < NUM_CELULAS; i++) begin
      total = total + {5'd0, mapa[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/gerador_pisca.sv
// Free-running blink generator: the phase flips every PISCA_DIV clocks.
module gerador_pisca #(
  parameter int PISCA_DIV = 190
) (
  input  logic clock,
  input  logic reset,
  output logic fase
);

  localparam int CW = (PISCA_DIV > 1) ? $clog2(PISCA_DIV) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(PISCA_DIV - 1);

  logic [CW-1:0] contador;

  // Count 0..PISCA_DIV-1 and toggle the phase on every wrap.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      contador <= '0;
      fase     <= 1'b0;
    end else if (contador == ULTIMO) begin
      contador <= '0;
      fase     <= ~fase;
    end else begin
      contador <= contador + 1'b1;
    end
  end

endmodule

// File: rtl/registro_ataques.sv
// Attack register for a 5x7 battleship board: snapshots the fleet when the
// attack phase begins, records shots, tracks hits/attempts, decides victory
// or defeat and produces the registered LED matrix image and status outputs.
module registro_ataques
  import registro_ataques_pkg::*;
#(
  parameter int TENTATIVAS_MAX = 20,
  parameter int PISCA_DIV      = 190
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       modo_ataque,
  input  logic       confirmar_ataque,
  input  logic [2:0] ataque_colunas,
  input  logic [2:0] ataque_linhas,
  input  logic [6:0] coluna1_posicionamento,
  input  logic [6:0] coluna2_posicionamento,
  input  logic [6:0] coluna3_posicionamento,
  input  logic [6:0] coluna4_posicionamento,
  input  logic [6:0] coluna5_posicionamento,
  output logic [6:0] coluna1_saida,
  output logic [6:0] coluna2_saida,
  output logic [6:0] coluna3_saida,
  output logic [6:0] coluna4_saida,
  output logic [6:0] coluna5_saida,
  output logic [1:0] ledRGB,
  output logic [4:0] tentativas,
  output logic       fim_jogo
);

  localparam logic [4:0] TENT_LIMITE = 5'(TENTATIVAS_MAX);

  estado_t     estado, estado_prox;
  mapa_t       frota, frota_prox;
  mapa_t       tiros, tiros_prox;
  mapa_t       saida_q, exibir;
  mapa_t       posicionamento;
  mapa_t       alvo;
  logic [5:0]  acertos, acertos_prox;
  logic [5:0]  navios;
  logic [5:0]  celula;
  logic [4:0]  tent_prox;
  logic [1:0]  led_prox;
  logic        coords_validas, ja_atirado, acerto, tiro_aceito;
  logic        fase;

  gerador_pisca #(
    .PISCA_DIV(PISCA_DIV)
  ) u_pisca (
    .clock(clock),
    .reset(reset),
    .fase (fase)
  );

  assign posicionamento = {coluna5_posicionamento, coluna4_posicionamento,
                           coluna3_posicionamento, coluna2_posicionamento,
                           coluna1_posicionamento};
  assign {coluna5_saida, coluna4_saida, coluna3_saida,
          coluna2_saida, coluna1_saida} = saida_q;

  // Target decode: one-hot cell mask, empty when coordinates are off-board.
  assign coords_validas = (ataque_colunas < 3'(NUM_COLUNAS)) &&
                          (ataque_linhas  < 3'(NUM_LINHAS));
  assign celula = 6'(ataque_colunas) * 6'(NUM_LINHAS) + 6'(ataque_linhas);
  assign alvo   = coords_validas ? ({{(NUM_CELULAS-1){1'b0}}, 1'b1} << celula) : '0;
  assign ja_atirado  = |(tiros & alvo);
  assign acerto      = |(frota & alvo);
  assign tiro_aceito = confirmar_ataque && coords_validas && !ja_atirado;
  assign navios      = contar_celulas(frota);

  // Game FSM and scoreboard: next values, with win/defeat judged on post-shot counts.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_prox  = estado;
    frota_prox   = frota;
    tiros_prox   = tiros;
    acertos_prox = acertos;
    tent_prox    = tentativas;
    led_prox     = ledRGB;
    if (!modo_ataque) begin
      estado_prox  = POSICIONAR;
      tiros_prox   = '0;
      acertos_prox = '0;
      tent_prox    = '0;
      led_prox     = LED_APAGADO;
    end else begin
      case (estado)
        POSICIONAR: begin
          estado_prox  = ATACAR;
          frota_prox   = posicionamento;
          tiros_prox   = '0;
          acertos_prox = '0;
          tent_prox    = '0;
          led_prox     = LED_APAGADO;
        end
        ATACAR: begin
          if (tiro_aceito) begin
            tiros_prox   = tiros | alvo;
            tent_prox    = tentativas + 5'd1;
            acertos_prox = acertos + {5'd0, acerto};
            led_prox     = acerto ? LED_ACERTO : LED_ERRO;
            if ((frota != '0) && (acertos_prox == navios)) begin
              estado_prox = VITORIA;
              led_prox    = LED_VITORIA;
            end else if (tent_prox == TENT_LIMITE) begin
              estado_prox = DERROTA;
              led_prox    = LED_ERRO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix image for the state being entered, so it updates with the scoreboard.
  always_comb begin
    case (estado_prox)
      POSICIONAR: exibir = posicionamento;
      ATACAR:     exibir = (tiros_prox & frota_prox) |
                           (tiros_prox & ~frota_prox & {NUM_CELULAS{fase}});
      VITORIA:    exibir = frota_prox;
      default:    exibir = frota_prox & {NUM_CELULAS{fase}};
    endcase
  end

  // State, scoreboard and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= POSICIONAR;
      frota      <= '0;
      tiros      <= '0;
      acertos    <= '0;
      tentativas <= '0;
      ledRGB     <= LED_APAGADO;
      saida_q    <= '0;
      fim_jogo   <= 1'b0;
    end else begin
      estado     <= estado_prox;
      frota      <= frota_prox;
      tiros      <= tiros_prox;
      acertos    <= acertos_prox;
      tentativas <= tent_prox;
      ledRGB     <= led_prox;
      saida_q    <= exibir;
      fim_jogo   <= (estado_prox == VITORIA) || (estado_prox == DERROTA);
    end
  end

endmodule

// File: tb/tb_registro_ataques.sv
// Self-checking bench: three instances (TENTATIVAS_MAX 20, 4, 2) share the
// same stimulus; directed scenarios check constants, the random run checks a
// game-level reference model.
module tb_registro_ataques;

  localparam int DIV = 6;
  localparam int N   = 3;
  localparam int E_POS = 0, E_ATQ = 1, E_VIT = 2, E_DER = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        modo  = 1'b0;
  logic        fire  = 1'b0;
  logic [2:0]  col   = '0;
  logic [2:0]  lin   = '0;
  logic [34:0] mapa  = '0;

  logic [6:0]  saida [N][5];
  logic [1:0]  led   [N];
  logic [4:0]  tent  [N];
  logic        fim   [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int MAX_G = (g == 0) ? 20 : (g == 1) ? 4 : 2;
    registro_ataques #(
      .TENTATIVAS_MAX(MAX_G),
      .PISCA_DIV     (DIV)
    ) u_dut (
      .clock                 (clock),
      .reset                 (reset),
      .modo_ataque           (modo),
      .confirmar_ataque      (fire),
      .ataque_colunas        (col),
      .ataque_linhas         (lin),
      .coluna1_posicionamento(mapa[6:0]),
      .coluna2_posicionamento(mapa[13:7]),
      .coluna3_posicionamento(mapa[20:14]),
      .coluna4_posicionamento(mapa[27:21]),
      .coluna5_posicionamento(mapa[34:28]),
      .coluna1_saida         (saida[g][0]),
      .coluna2_saida         (saida[g][1]),
      .coluna3_saida         (saida[g][2]),
      .coluna4_saida         (saida[g][3]),
      .coluna5_saida         (saida[g][4]),
      .ledRGB                (led[g]),
      .tentativas            (tent[g]),
      .fim_jogo              (fim[g])
    );
  end

  function automatic int max_de(input int i);
    return (i == 0) ? 20 : (i == 1) ? 4 : 2;
  endfunction

  function automatic logic [34:0] plano(input int i);
    return {saida[i][4], saida[i][3], saida[i][2], saida[i][1], saida[i][0]};
  endfunction

  // ---------------- game-level reference model ----------------
  int          m_estado  [N];
  int          m_acertos [N];
  int          m_tent    [N];
  logic [1:0]  m_led     [N];
  logic [34:0] m_frota   [N];
  logic [34:0] m_tiros   [N];
  logic [34:0] m_exp     [N];
  logic [34:0] m_mask    [N];
  int          mk;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_estado[i] = E_POS; m_acertos[i] = 0; m_tent[i] = 0; m_led[i] = 2'b00;
      m_frota[i] = '0; m_tiros[i] = '0; m_exp[i] = '0; m_mask[i] = '1;
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_estado[i] = E_POS; m_acertos[i] = 0; m_tent[i] = 0; m_led[i] = 2'b00;
        m_frota[i] = '0; m_tiros[i] = '0; m_exp[i] = '0; m_mask[i] = '1;
      end else begin
        if (!modo) begin
          m_estado[i] = E_POS; m_tiros[i] = '0; m_acertos[i] = 0; m_tent[i] = 0;
          m_led[i] = 2'b00;
        end else if (m_estado[i] == E_POS) begin
          m_estado[i] = E_ATQ; m_frota[i] = mapa; m_tiros[i] = '0;
          m_acertos[i] = 0; m_tent[i] = 0; m_led[i] = 2'b00;
        end else if (m_estado[i] == E_ATQ && fire && col < 5 && lin < 7) begin
          mk = int'(col) * 7 + int'(lin);
          if (!m_tiros[i][mk]) begin
            m_tiros[i][mk] = 1'b1;
            m_tent[i]++;
            if (m_frota[i][mk]) m_acertos[i]++;
            m_led[i] = m_frota[i][mk] ? 2'b10 : 2'b01;
            if (m_frota[i] != 0 && m_acertos[i] == $countones(m_frota[i])) begin
              m_estado[i] = E_VIT; m_led[i] = 2'b11;
            end else if (m_tent[i] == max_de(i)) begin
              m_estado[i] = E_DER; m_led[i] = 2'b01;
            end
          end
        end
        case (m_estado[i])
          E_POS: begin m_exp[i] = mapa; m_mask[i] = '1; end
          E_ATQ: begin
            m_exp[i]  = m_tiros[i] & m_frota[i];
            m_mask[i] = ~(m_tiros[i] & ~m_frota[i]);
          end
          E_VIT: begin m_exp[i] = m_frota[i]; m_mask[i] = '1; end
          default: begin m_exp[i] = '0; m_mask[i] = ~m_frota[i]; end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ciclo();
    @(negedge clock);
  endtask

  task automatic disparar(input int c, input int r);
    col = 3'(c); lin = 3'(r); fire = 1'b1;
    @(negedge clock);
    fire = 1'b0;
  endtask

  task automatic iniciar_jogo(input logic [34:0] m);
    reset = 1'b1; fire = 1'b0;
    ciclo();
    reset = 1'b0; modo = 1'b0; mapa = m;
    ciclo();
    modo = 1'b1;
    ciclo();
  endtask

  function automatic logic [34:0] mapa_esparso();
    logic [34:0] m;
    m = '0;
    for (int n = 0; n < int'($urandom_range(0, 4)); n++) m[$urandom_range(0, 34)] = 1'b1;
    return m;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    modo = 1'b1; fire = 1'b1; col = 3'd1; lin = 3'd1; mapa = 35'h7_FFFF_FFFF;
    reset = 1'b1;
    ciclo(); ciclo();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (plano(i) !== 35'd0 || led[i] !== 2'b00 || tent[i] !== 5'd0 || fim[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset[%0d]: saida=%h led=%b tent=%0d fim=%b, required all zero",
                 i, plano(i), led[i], tent[i], fim[i]);
      end
    end
    fire = 1'b0; modo = 1'b0; mapa = 35'h1_2345_6789;
    reset = 1'b0;
    ciclo();
    n_checks++;
    if (plano(0) !== 35'h1_2345_6789) begin
      n_errors++;
      $display("FAIL reset_first_edge: saida=%h required %h", plano(0), 35'h1_2345_6789);
    end
  endtask

  task automatic test_basico();
    int altos, trocas;
    logic ant;
    iniciar_jogo(35'd1 | (35'd1 << 34));
    disparar(0, 0);
    n_checks++;
    if (led[0] !== 2'b10 || tent[0] !== 5'd1 || saida[0][0] !== 7'b0000001 || saida[0][4] !== 7'd0) begin
      n_errors++;
      $display("FAIL hit: led=%b tent=%0d col1=%b col5=%b, required 10 1 0000001 0000000",
               led[0], tent[0], saida[0][0], saida[0][4]);
    end
    disparar(1, 3);
    n_checks++;
    if (led[0] !== 2'b01 || tent[0] !== 5'd2) begin
      n_errors++;
      $display("FAIL miss: led=%b tent=%0d, required 01 2", led[0], tent[0]);
    end
    altos = 0; trocas = 0; ant = saida[0][1][3];
    for (int t = 0; t < 4 * DIV; t++) begin
      ciclo();
      if (saida[0][1][3]) altos++;
      if (saida[0][1][3] !== ant) trocas++;
      ant = saida[0][1][3];
      n_checks++;
      if ((saida[0][1] & 7'b1110111) !== 7'd0 || saida[0][0] !== 7'b0000001) begin
        n_errors++;
        $display("FAIL blink_steady: col1=%b col2=%b", saida[0][0], saida[0][1]);
      end
    end
    n_checks++;
    if (altos != 2 * DIV || trocas < 3) begin
      n_errors++;
      $display("FAIL miss_blink: high=%0d toggles=%0d, required high=%0d toggles>=3",
               altos, trocas, 2 * DIV);
    end
  endtask

  task automatic test_ignorados();
    disparar(0, 0);
    n_checks++;
    if (tent[0] !== 5'd2 || led[0] !== 2'b01) begin
      n_errors++;
      $display("FAIL repeat_shot: tent=%0d led=%b, required 2 01", tent[0], led[0]);
    end
    disparar(5, 2);
    n_checks++;
    if (tent[0] !== 5'd2 || led[0] !== 2'b01) begin
      n_errors++;
      $display("FAIL col_out_of_range: tent=%0d led=%b, required 2 01", tent[0], led[0]);
    end
    disparar(2, 7);
    n_checks++;
    if (tent[0] !== 5'd2 || led[0] !== 2'b01) begin
      n_errors++;
      $display("FAIL row_out_of_range: tent=%0d led=%b, required 2 01", tent[0], led[0]);
    end
  endtask

  task automatic test_vitoria();
    logic [34:0] f;
    f = 35'd1 | (35'd1 << 8) | (35'd1 << 34);
    iniciar_jogo(f);
    mapa = '0;
    disparar(0, 0);
    disparar(4, 6);
    n_checks++;
    if (fim[0] !== 1'b0 || led[0] !== 2'b10) begin
      n_errors++;
      $display("FAIL pre_victory: fim=%b led=%b, required 0 10", fim[0], led[0]);
    end
    disparar(1, 1);
    n_checks++;
    if (led[0] !== 2'b11 || fim[0] !== 1'b1 || tent[0] !== 5'd3 || plano(0) !== f) begin
      n_errors++;
      $display("FAIL victory: led=%b fim=%b tent=%0d saida=%h, required 11 1 3 %h",
               led[0], fim[0], tent[0], plano(0), f);
    end
    mapa = 35'h7_0F0F_0F0F;
    disparar(2, 2);
    ciclo(); ciclo();
    n_checks++;
    if (plano(0) !== f || tent[0] !== 5'd3 || led[0] !== 2'b11) begin
      n_errors++;
      $display("FAIL victory_hold: saida=%h tent=%0d led=%b, required %h 3 11",
               plano(0), tent[0], led[0], f);
    end
  endtask

  task automatic test_derrota();
    int altos;
    iniciar_jogo(35'd1 << 34);
    disparar(0, 0); disparar(0, 1); disparar(2, 3);
    n_checks++;
    if (fim[1] !== 1'b0 || tent[1] !== 5'd3) begin
      n_errors++;
      $display("FAIL pre_defeat: fim=%b tent=%0d, required 0 3", fim[1], tent[1]);
    end
    disparar(3, 5);
    n_checks++;
    if (fim[1] !== 1'b1 || led[1] !== 2'b01 || tent[1] !== 5'd4) begin
      n_errors++;
      $display("FAIL defeat: fim=%b led=%b tent=%0d, required 1 01 4", fim[1], led[1], tent[1]);
    end
    disparar(4, 6);
    n_checks++;
    if (fim[1] !== 1'b1 || led[1] !== 2'b01 || tent[1] !== 5'd4) begin
      n_errors++;
      $display("FAIL defeat_ignores: fim=%b led=%b tent=%0d, required 1 01 4", fim[1], led[1], tent[1]);
    end
    altos = 0;
    for (int t = 0; t < 2 * DIV; t++) begin
      ciclo();
      if (saida[1][4][6]) altos++;
      n_checks++;
      if ((plano(1) & ~(35'd1 << 34)) !== 35'd0) begin
        n_errors++;
        $display("FAIL defeat_display: saida=%h, only bit 34 may light", plano(1));
      end
    end
    n_checks++;
    if (altos != DIV) begin
      n_errors++;
      $display("FAIL defeat_blink: high=%0d required %0d", altos, DIV);
    end
  endtask

  task automatic test_empate();
    iniciar_jogo(35'd1 << 16);
    disparar(0, 0);
    n_checks++;
    if (led[2] !== 2'b01 || fim[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL tie_first_miss: led=%b fim=%b, required 01 0", led[2], fim[2]);
    end
    disparar(2, 2);
    n_checks++;
    if (led[2] !== 2'b11 || fim[2] !== 1'b1 || tent[2] !== 5'd2) begin
      n_errors++;
      $display("FAIL tie_win_priority: led=%b fim=%b tent=%0d, required 11 1 2", led[2], fim[2], tent[2]);
    end
  endtask

  task automatic test_frota_vazia();
    iniciar_jogo('0);
    disparar(0, 0); disparar(1, 1); disparar(2, 2);
    n_checks++;
    if (fim[0] !== 1'b0 || led[0] !== 2'b01) begin
      n_errors++;
      $display("FAIL empty_fleet_no_win: fim=%b led=%b, required 0 01", fim[0], led[0]);
    end
    disparar(3, 3);
    n_checks++;
    if (fim[1] !== 1'b1 || led[1] !== 2'b01 || tent[1] !== 5'd4) begin
      n_errors++;
      $display("FAIL empty_fleet_defeat: fim=%b led=%b tent=%0d, required 1 01 4", fim[1], led[1], tent[1]);
    end
  endtask

  task automatic test_saidas_meio();
    iniciar_jogo(35'h0_0000_0F0F);
    disparar(0, 0); disparar(3, 3); disparar(4, 4);
    reset = 1'b1;
    ciclo();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (plano(i) !== 35'd0 || led[i] !== 2'b00 || tent[i] !== 5'd0 || fim[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL midgame_reset[%0d]: saida=%h led=%b tent=%0d fim=%b, required zero",
                 i, plano(i), led[i], tent[i], fim[i]);
      end
    end
    reset = 1'b0;
    iniciar_jogo(35'h0_0000_0F0F);
    disparar(0, 0); disparar(3, 3);
    modo = 1'b0;
    ciclo();
    n_checks++;
    if (tent[0] !== 5'd0 || led[0] !== 2'b00 || fim[0] !== 1'b0 || plano(0) !== 35'h0_0000_0F0F) begin
      n_errors++;
      $display("FAIL midgame_exit: tent=%0d led=%b fim=%b saida=%h, required 0 00 0 %h",
               tent[0], led[0], fim[0], plano(0), 35'h0_0000_0F0F);
    end
  endtask

  task automatic test_aleatorio();
    int inicio;
    reset = 1'b1; modo = 1'b1; fire = 1'b0;
    ciclo();
    reset = 1'b0;
    for (int t = 0; t < 800; t++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 59) == 0) modo = ~modo;
      if ($urandom_range(0, 9) == 0) mapa = mapa_esparso();
      fire = $urandom_range(0, 1) == 1;
      col = 3'($urandom_range(0, 5));
      lin = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0 && m_frota[0] != 0) begin
        inicio = $urandom_range(0, 34);
        for (int k = 0; k < 35; k++) begin
          if (m_frota[0][(inicio + k) % 35]) begin
            col = 3'(((inicio + k) % 35) / 7);
            lin = 3'(((inicio + k) % 35) % 7);
            break;
          end
        end
      end
      ciclo();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (led[i] !== m_led[i] || tent[i] !== 5'(m_tent[i]) ||
            fim[i] !== (m_estado[i] >= E_VIT) ||
            (plano(i) & m_mask[i]) !== (m_exp[i] & m_mask[i])) begin
          n_errors++;
          $display("FAIL random[%0d] step %0d: led=%b tent=%0d fim=%b saida=%h, required led=%b tent=%0d fim=%b saida=%h mask=%h",
                   i, t, led[i], tent[i], fim[i], plano(i), m_led[i], m_tent[i],
                   (m_estado[i] >= E_VIT), m_exp[i], m_mask[i]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basico();
    test_ignorados();
    test_vitoria();
    test_derrota();
    test_empate();
    test_frota_vazia();
    test_saidas_meio();
    test_aleatorio();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/registro_ataques.md
REGISTRO_ATAQUES -- requirements
Module: registro_ataques

Interface
REQ-001 Parameter TENTATIVAS_MAX, default 20: shots allowed before defeat, range 1..31.
REQ-002 Parameter PISCA_DIV, default 190: clock cycles per blink half-period, about 0.5 s at 381 Hz.
REQ-003 clock  input  1  single system clock (381 Hz display clock); all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 modo_ataque  input  1  0 = positioning, 1 = attack.
REQ-006 confirmar_ataque  input  1  debounced single-cycle fire pulse.
REQ-007 ataque_colunas  input  3  target column index: 0..4 valid, 0 = coluna1.
REQ-008 ataque_linhas  input  3  target row index: 0..6 valid, value r selects bit r.
REQ-009 coluna1_posicionamento..coluna5_posicionamento  input  7 each  ship map; bit set = ship cell.
REQ-010 coluna1_saida..coluna5_saida  output  7 each  registered LED column data for the matrix scanner.
REQ-011 ledRGB  output  2  registered: 00 idle, 01 miss, 10 hit, 11 victory.
REQ-012 tentativas  output  5  registered count of accepted shots.
REQ-013 fim_jogo  output  1  registered; high in VITORIA or DERROTA.

Function
REQ-014 FSM states: POSICIONAR, ATACAR, VITORIA, DERROTA.
REQ-015 POSICIONAR -> ATACAR when modo_ataque=1; on that same edge:
- snapshot the ship map into internal register `frota`
- clear the 35-bit shot map, tentativas and acertos
- set ledRGB to 00
REQ-016 Any state -> POSICIONAR on the edge after modo_ataque=0; shot map, counters and ledRGB are cleared on that edge.
REQ-017 Shot acceptance, in ATACAR only: confirmar_ataque=1 with column<5, row<7 and target cell not yet shot.
REQ-018 Accepted shot at edge N, all visible at N+1:
- set the shot bit
- tentativas +1
- acertos +1 if `frota` has that cell
- ledRGB 10 on hit, 01 on miss
REQ-019 Ignored with no state change of any kind:
- out-of-range coordinates
- repeat shots on an already-shot cell
- pulses outside ATACAR
REQ-020 Win and defeat checks use post-shot values on the same edge, so the state change is visible at N+1:
- acertos equals popcount(frota), frota nonzero -> VITORIA, ledRGB 11
- otherwise tentativas equals TENTATIVAS_MAX -> DERROTA, ledRGB 01
REQ-021 Win has priority when the final shot both sinks the fleet and reaches TENTATIVAS_MAX.
REQ-022 Zero-ship snapshot: win detection is disabled and only defeat is reachable.
REQ-023 acertos is 6 bits and tentativas is 5 bits; neither wraps, because counting stops on leaving ATACAR.
REQ-024 Display by state:
- POSICIONAR: saida = live posicionamento inputs, registered one cycle
- ATACAR: hit cells steady on, miss cells show blink phase, unshot cells off; ship cells are never revealed
- VITORIA: frota steady
- DERROTA: frota AND blink phase
REQ-025 Blink phase toggles every PISCA_DIV cycles; the counter runs freely and wraps to 0 after PISCA_DIV-1.
REQ-026 Ship-map inputs changing during ATACAR, VITORIA or DERROTA have no effect on frota.

Reset
REQ-027 reset=1 at an edge, with priority over all inputs and including mid-game:
- FSM to POSICIONAR
- shot map, frota, acertos, tentativas, blink counter and blink phase cleared
- all saida columns 0, ledRGB 00, fim_jogo 0
REQ-028 The first edge after reset deasserts behaves per REQ-015/REQ-024 from current inputs.

Structure
REQ-029 Shared package holds:
- NUM_COLUNAS=5 and NUM_LINHAS=7
- the FSM state enum
- ledRGB code constants (LED_APAGADO, LED_ERRO, LED_ACERTO, LED_VITORIA)
REQ-030 Sub-module gerador_pisca (counter plus phase flop, parameter PISCA_DIV, ports clock/reset/fase) holds the blink logic; everything else stays in registro_ataques.

Verification
REQ-031 Basic hit/miss: ship map coluna1=0000001, modo_ataque 0->1, fire (0,0):
- ledRGB=10, tentativas=1, coluna1_saida=0000001
- then fire (1,3): ledRGB=01, coluna2_saida bit3 blinks with period 2*PISCA_DIV
REQ-032 Victory: 3-cell fleet, three hits -> VITORIA at the edge after the third pulse, ledRGB=11, fim_jogo=1, display=frota.
REQ-033 Defeat: TENTATIVAS_MAX=4 with misses at four distinct cells -> DERROTA, tentativas=4, further pulses ignored.
REQ-034 Ignored shots: repeat shot (0,0), coordinates (5,2) and (2,7) -> tentativas and ledRGB unchanged.
REQ-035 Simultaneous win and defeat: TENTATIVAS_MAX=2, 1-cell fleet, miss then hit -> VITORIA, not DERROTA.
REQ-036 Mid-game exits:
- reset after 3 shots -> all outputs 0 next cycle
- separately, modo_ataque=0 mid-game -> POSICIONAR with tentativas=0
